// File: rtl/decode_execute_pair_reg.sv
// -----------------------------------------------------------------------------
// decode_execute_pair_reg
//
// Dual-lane ID/EX pipeline register between the dual main decoder and the
// execute stage.
//
// Each lane's control, operand data and register specifiers are captured every
// cycle. If lane 2 reads the register that lane 1 writes (intra-pair RAW), the
// pair is split across two cycles:
//   - lane 1 issues first;
//   - lane 2 issues one cycle later;
//   - upstream is held in the meantime through split_stall.
//
// Handshake: split_stall is the only back-pressure signal and it is purely
// combinational. While it is 1, the IF/ID stage must keep the current pair
// stable into the next cycle. The pair counts as consumed on any rising edge
// where split_stall is 0 and stall is 0 (or flush is 1).
//
// Configuration macro:
//   DUAL_MEM_SPLIT_EN - when defined, a pair is also split when both lanes
//                       access memory (MemWrite | ResultSrc), because there is
//                       a single data-memory port. The split sequence is the
//                       same as for a RAW hazard. When undefined, only the RAW
//                       term splits.
//
// Parameters:
//   XLEN   - datapath width; data bundle = {RD1,RD2,Imm,PC} (4*XLEN bits)
//   CTRL_W - control bundle width
//            {RegWrite,ALUSrc,MemWrite,ResultSrc,Branch,ALUControl[2:0]},
//            MSB first
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   stall        in   hazard-unit stall; holds all registers and state
//   flush        in   branch flush; loads bubbles into both lanes
//   vld1_d       in   lane1 decode-stage valid
//   ctrl1_d      in   lane1 control bundle
//   data1_d      in   lane1 {RD1,RD2,Imm,PC}
//   regs1_d      in   lane1 {rs1,rs2,rd}
//   vld2_d .. regs2_d                 lane2 equivalents
//   vld1_e       out  lane1 execute-stage valid
//   ctrl1_e      out  lane1 registered control
//   data1_e      out  lane1 registered data
//   regs1_e      out  lane1 registered specifiers
//   vld2_e .. regs2_e                 lane2 equivalents
//   split_stall  out  combinational; 1 = hold IF/ID this cycle
// -----------------------------------------------------------------------------
module decode_execute_pair_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,

  input  logic                vld1_d,
  input  logic [CTRL_W-1:0]   ctrl1_d,
  input  logic [4*XLEN-1:0]   data1_d,
  input  logic [14:0]         regs1_d,

  input  logic                vld2_d,
  input  logic [CTRL_W-1:0]   ctrl2_d,
  input  logic [4*XLEN-1:0]   data2_d,
  input  logic [14:0]         regs2_d,

  output logic                vld1_e,
  output logic [CTRL_W-1:0]   ctrl1_e,
  output logic [4*XLEN-1:0]   data1_e,
  output logic [14:0]         regs1_e,

  output logic                vld2_e,
  output logic [CTRL_W-1:0]   ctrl2_e,
  output logic [4*XLEN-1:0]   data2_e,
  output logic [14:0]         regs2_e,

  output logic                split_stall
);

  // ---------------------------------------------------------------------------
  // Control bundle bit positions (MSB first)
  // ---------------------------------------------------------------------------
  localparam int CB_REGWRITE  = CTRL_W - 1;
  localparam int CB_MEMWRITE  = CTRL_W - 3;
  localparam int CB_RESULTSRC = CTRL_W - 4;

  // ---------------------------------------------------------------------------
  // FSM encoding
  // ---------------------------------------------------------------------------
  localparam logic [0:0] ST_PAIR  = 1'b0;
  localparam logic [0:0] ST_SPLIT = 1'b1;

  // ---------------------------------------------------------------------------
  // Register-specifier fields: {rs1[14:10], rs2[9:5], rd[4:0]}
  // ---------------------------------------------------------------------------
  logic [4:0] rd1;
  logic [4:0] rs1_2;
  logic [4:0] rs2_2;

  assign rd1   = regs1_d[4:0];
  assign rs1_2 = regs2_d[14:10];
  assign rs2_2 = regs2_d[9:5];

  // ---------------------------------------------------------------------------
  // Split detection
  // ---------------------------------------------------------------------------
  logic both_vld;
  logic raw_hazard;
  logic mem_conflict;
  logic hazard;

  assign both_vld = vld1_d & vld2_d;

  // rs2 is compared even when lane 2 has no rs2 operand. This can split a
  // pair that did not need it, but it never misses a real dependency.
  assign raw_hazard = both_vld & ctrl1_d[CB_REGWRITE] & (rd1 != 5'd0) &
                      ((rd1 == rs1_2) | (rd1 == rs2_2));

`ifdef DUAL_MEM_SPLIT_EN
  assign mem_conflict = both_vld &
                        (ctrl1_d[CB_MEMWRITE] | ctrl1_d[CB_RESULTSRC]) &
                        (ctrl2_d[CB_MEMWRITE] | ctrl2_d[CB_RESULTSRC]);
`else
  assign mem_conflict = 1'b0;
`endif

  assign hazard = raw_hazard | mem_conflict;

  // ---------------------------------------------------------------------------
  // State and pipeline registers
  // ---------------------------------------------------------------------------
  logic [0:0]         state_q,   state_d;

  logic               l1_vld_q,  l1_vld_d;
  logic [CTRL_W-1:0]  l1_ctrl_q, l1_ctrl_d;
  logic [4*XLEN-1:0]  l1_data_q, l1_data_d;
  logic [14:0]        l1_regs_q, l1_regs_d;

  logic               l2_vld_q,  l2_vld_d;
  logic [CTRL_W-1:0]  l2_ctrl_q, l2_ctrl_d;
  logic [4*XLEN-1:0]  l2_data_q, l2_data_d;
  logic [14:0]        l2_regs_q, l2_regs_d;

  // ---------------------------------------------------------------------------
  // Upstream hold request
  // ---------------------------------------------------------------------------
  // A split is only requested from PAIR. In SPLIT the pair being held is
  // released, so the hazard is not re-evaluated there. The request stays
  // asserted under stall so that IF/ID keeps holding the pair.
  assign split_stall = ~rst & ~flush & (state_q == ST_PAIR) & hazard;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // A bubble clears only valid and control. Data and specifiers keep their old
  // value because downstream ignores them when valid is low.
  always_comb begin
    state_d   = state_q;
    l1_vld_d  = l1_vld_q;
    l1_ctrl_d = l1_ctrl_q;
    l1_data_d = l1_data_q;
    l1_regs_d = l1_regs_q;
    l2_vld_d  = l2_vld_q;
    l2_ctrl_d = l2_ctrl_q;
    l2_data_d = l2_data_q;
    l2_regs_d = l2_regs_q;

    if (flush) begin
      l1_vld_d  = 1'b0;
      l1_ctrl_d = '0;
      l2_vld_d  = 1'b0;
      l2_ctrl_d = '0;
      state_d   = ST_PAIR;
    end else if (!stall) begin
      case (state_q)
        ST_PAIR: begin
          l1_vld_d  = vld1_d;
          l1_ctrl_d = vld1_d ? ctrl1_d : '0;
          l1_data_d = data1_d;
          l1_regs_d = regs1_d;
          if (hazard) begin
            // Lane 1 goes now; lane 2 waits one cycle as a bubble.
            l2_vld_d  = 1'b0;
            l2_ctrl_d = '0;
            state_d   = ST_SPLIT;
          end else begin
            l2_vld_d  = vld2_d;
            l2_ctrl_d = vld2_d ? ctrl2_d : '0;
            l2_data_d = data2_d;
            l2_regs_d = regs2_d;
          end
        end
        default: begin
          // ST_SPLIT: upstream still presents the same pair. Lane 1 was
          // issued last cycle, so only lane 2 is taken now.
          l1_vld_d  = 1'b0;
          l1_ctrl_d = '0;
          l2_vld_d  = vld2_d;
          l2_ctrl_d = vld2_d ? ctrl2_d : '0;
          l2_data_d = data2_d;
          l2_regs_d = regs2_d;
          state_d   = ST_PAIR;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_PAIR;
      l1_vld_q  <= 1'b0;
      l1_ctrl_q <= '0;
      l1_data_q <= '0;
      l1_regs_q <= '0;
      l2_vld_q  <= 1'b0;
      l2_ctrl_q <= '0;
      l2_data_q <= '0;
      l2_regs_q <= '0;
    end else begin
      state_q   <= state_d;
      l1_vld_q  <= l1_vld_d;
      l1_ctrl_q <= l1_ctrl_d;
      l1_data_q <= l1_data_d;
      l1_regs_q <= l1_regs_d;
      l2_vld_q  <= l2_vld_d;
      l2_ctrl_q <= l2_ctrl_d;
      l2_data_q <= l2_data_d;
      l2_regs_q <= l2_regs_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign vld1_e  = l1_vld_q;
  assign ctrl1_e = l1_ctrl_q;
  assign data1_e = l1_data_q;
  assign regs1_e = l1_regs_q;

  assign vld2_e  = l2_vld_q;
  assign ctrl2_e = l2_ctrl_q;
  assign data2_e = l2_data_q;
  assign regs2_e = l2_regs_q;

endmodule

// File: tb/tb_decode_execute_pair_reg.sv
// -----------------------------------------------------------------------------
// tb_decode_execute_pair_reg
//
// Bench for decode_execute_pair_reg.
//
// A reference model tracks the expected execute-stage lanes. A pair that must
// be split has its lane 2 parked in exp_q; that entry is issued one
// unstalled, unflushed cycle later.
//
// Directed cases cover reset, plain pairs, RAW splits, x0, flush and stall
// during a split, and memory pairs. They are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_decode_execute_pair_reg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 8;
  localparam int DW     = 4 * XLEN;
  localparam int W      = 1 + CTRL_W + DW + 15;

  typedef logic [DW-1:0] cmp_t;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // ---------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst, stall, flush;
  logic              vld1_d, vld2_d;
  logic [CTRL_W-1:0] ctrl1_d, ctrl2_d;
  logic [DW-1:0]     data1_d, data2_d;
  logic [14:0]       regs1_d, regs2_d;
  logic              vld1_e, vld2_e;
  logic [CTRL_W-1:0] ctrl1_e, ctrl2_e;
  logic [DW-1:0]     data1_e, data2_e;
  logic [14:0]       regs1_e, regs2_e;
  logic              split_stall;

  always #5 clk = ~clk;

  decode_execute_pair_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .vld1_d(vld1_d), .ctrl1_d(ctrl1_d), .data1_d(data1_d), .regs1_d(regs1_d),
    .vld2_d(vld2_d), .ctrl2_d(ctrl2_d), .data2_d(data2_d), .regs2_d(regs2_d),
    .vld1_e(vld1_e), .ctrl1_e(ctrl1_e), .data1_e(data1_e), .regs1_e(regs1_e),
    .vld2_e(vld2_e), .ctrl2_e(ctrl2_e), .data2_e(data2_e), .regs2_e(regs2_e),
    .split_stall(split_stall)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0]      exp_q[$];  // lane-2 instruction waiting to issue
  logic              m_vld1, m_vld2;
  logic [CTRL_W-1:0] m_ctrl1, m_ctrl2;
  logic [DW-1:0]     m_data1, m_data2;
  logic [14:0]       m_regs1, m_regs2;

  task automatic check_eq(input string tag, input cmp_t act, input cmp_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: should this pair be split?
  // ---------------------------------------------------------------------------
  function automatic logic model_split(
    input logic v1, input logic [7:0] c1, input logic [14:0] r1,
    input logic v2, input logic [7:0] c2, input logic [14:0] r2);
    logic       s;
    logic [4:0] rd;
    rd = r1[4:0];
    s  = v1 && v2 && c1[7] && (rd != 5'd0) &&
         ((rd == r2[14:10]) || (rd == r2[9:5]));
`ifdef DUAL_MEM_SPLIT_EN
    s = s || (v1 && v2 && (c1[5] || c1[4]) && (c2[5] || c2[4]));
`endif
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic set_ctl(input logic r, input logic s, input logic f);
    rst   = r;
    stall = s;
    flush = f;
  endtask

  task automatic set_pair(
    input logic v1, input logic [7:0] c1, input logic [14:0] r1,
    input logic v2, input logic [7:0] c2, input logic [14:0] r2);
    vld1_d  = v1;
    ctrl1_d = c1;
    regs1_d = r1;
    data1_d = {$urandom, $urandom, $urandom, $urandom};
    vld2_d  = v2;
    ctrl2_d = c2;
    regs2_d = r2;
    data2_d = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // ---------------------------------------------------------------------------
  // One cycle: check split_stall, advance the model across the edge, then
  // compare the registered outputs.
  // Inputs must already be driven; this task is called just after a negedge.
  // ---------------------------------------------------------------------------
  task automatic step_cycle();
    logic         haz;
    logic         exp_ss;
    logic [W-1:0] b;

    #1;
    haz    = model_split(vld1_d, ctrl1_d, regs1_d, vld2_d, ctrl2_d, regs2_d);
    exp_ss = !rst && !flush && (exp_q.size() == 0) && haz;
    check_eq("split_stall", cmp_t'(split_stall), cmp_t'(exp_ss));

    if (rst) begin
      {m_vld1, m_ctrl1, m_data1, m_regs1} = '0;
      {m_vld2, m_ctrl2, m_data2, m_regs2} = '0;
      exp_q.delete();
    end else if (flush) begin
      m_vld1  = 1'b0;
      m_ctrl1 = '0;
      m_vld2  = 1'b0;
      m_ctrl2 = '0;
      exp_q.delete();
    end else if (!stall) begin
      if (exp_q.size() != 0) begin
        b       = exp_q.pop_front();
        m_vld1  = 1'b0;
        m_ctrl1 = '0;
        {m_vld2, m_ctrl2, m_data2, m_regs2} = b;
      end else begin
        m_vld1  = vld1_d;
        m_ctrl1 = vld1_d ? ctrl1_d : '0;
        m_data1 = data1_d;
        m_regs1 = regs1_d;
        if (haz) begin
          m_vld2  = 1'b0;
          m_ctrl2 = '0;
          exp_q.push_back({vld2_d, ctrl2_d, data2_d, regs2_d});
        end else begin
          m_vld2  = vld2_d;
          m_ctrl2 = vld2_d ? ctrl2_d : '0;
          m_data2 = data2_d;
          m_regs2 = regs2_d;
        end
      end
    end

    @(negedge clk);
    check_eq("vld1_e",  cmp_t'(vld1_e),  cmp_t'(m_vld1));
    check_eq("ctrl1_e", cmp_t'(ctrl1_e), cmp_t'(m_ctrl1));
    check_eq("vld2_e",  cmp_t'(vld2_e),  cmp_t'(m_vld2));
    check_eq("ctrl2_e", cmp_t'(ctrl2_e), cmp_t'(m_ctrl2));
    if (m_vld1) begin
      check_eq("data1_e", data1_e, m_data1);
      check_eq("regs1_e", cmp_t'(regs1_e), cmp_t'(m_regs1));
    end
    if (m_vld2) begin
      check_eq("data2_e", data2_e, m_data2);
      check_eq("regs2_e", cmp_t'(regs2_e), cmp_t'(m_regs2));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  localparam logic [7:0] C_ADD = 8'b1000_0000;  // RegWrite
  localparam logic [7:0] C_LW  = 8'b1101_0000;  // RegWrite, ALUSrc, ResultSrc
  localparam logic [7:0] C_SW  = 8'b0110_0000;  // ALUSrc, MemWrite

  initial begin
    m_vld1 = 0; m_ctrl1 = '0; m_data1 = '0; m_regs1 = '0;
    m_vld2 = 0; m_ctrl2 = '0; m_data2 = '0; m_regs2 = '0;
    set_ctl(1'b1, 1'b0, 1'b0);
    set_pair(1'b1, 8'($urandom), 15'($urandom), 1'b1, 8'($urandom), 15'($urandom));
    @(negedge clk);

    // 1: reset for two cycles with random inputs
    for (int i = 0; i < 2; i++) begin
      set_ctl(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      set_pair(1'b1, 8'($urandom), 15'($urandom), 1'b1, 8'($urandom), 15'($urandom));
      step_cycle();
    end
    check_eq("rst_data1", data1_e, '0);
    check_eq("rst_data2", data2_e, '0);
    check_eq("rst_regs1", cmp_t'(regs1_e), '0);
    check_eq("rst_regs2", cmp_t'(regs2_e), '0);
    check_eq("rst_vld1",  cmp_t'(vld1_e), '0);
    set_ctl(1'b0, 1'b0, 1'b0);

    // 2: independent pair issues together
    set_pair(1'b1, C_ADD, {5'd1, 5'd2, 5'd5}, 1'b1, C_ADD, {5'd7, 5'd8, 5'd6});
    step_cycle();
    check_eq("pair_vld1", cmp_t'(vld1_e), cmp_t'(1'b1));
    check_eq("pair_vld2", cmp_t'(vld2_e), cmp_t'(1'b1));

    // 3: RAW on rs1 splits the pair
    set_pair(1'b1, C_ADD, {5'd1, 5'd2, 5'd5}, 1'b1, C_ADD, {5'd5, 5'd8, 5'd6});
    step_cycle();
    check_eq("split_c1_vld2", cmp_t'(vld2_e), cmp_t'(1'b0));
    step_cycle();
    check_eq("split_c2_vld1", cmp_t'(vld1_e), cmp_t'(1'b0));
    check_eq("split_c2_vld2", cmp_t'(vld2_e), cmp_t'(1'b1));

    // 4: x0 destination never splits
    set_pair(1'b1, C_ADD, {5'd1, 5'd2, 5'd0}, 1'b1, C_ADD, {5'd0, 5'd3, 5'd6});
    step_cycle();
    check_eq("x0_vld2", cmp_t'(vld2_e), cmp_t'(1'b1));

    // 5a: flush while in SPLIT drops lane 2
    set_pair(1'b1, C_ADD, {5'd1, 5'd2, 5'd5}, 1'b1, C_ADD, {5'd3, 5'd5, 5'd6});
    step_cycle();
    set_ctl(1'b0, 1'b0, 1'b1);
    step_cycle();
    check_eq("flush_vld1", cmp_t'(vld1_e), cmp_t'(1'b0));
    check_eq("flush_vld2", cmp_t'(vld2_e), cmp_t'(1'b0));
    set_ctl(1'b0, 1'b0, 1'b0);
    set_pair(1'b1, C_ADD, {5'd1, 5'd2, 5'd9}, 1'b1, C_ADD, {5'd3, 5'd4, 5'd6});
    step_cycle();

    // 5b: stall for three cycles in SPLIT, then lane 2 issues
    set_pair(1'b1, C_ADD, {5'd1, 5'd2, 5'd5}, 1'b1, C_ADD, {5'd5, 5'd5, 5'd6});
    step_cycle();
    set_ctl(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step_cycle();
    check_eq("stall_hold_vld1", cmp_t'(vld1_e), cmp_t'(1'b1));
    set_ctl(1'b0, 1'b0, 1'b0);
    step_cycle();
    check_eq("stall_rel_vld2", cmp_t'(vld2_e), cmp_t'(1'b1));

    // 6: lw x3 / sw x4 with no RAW
    set_pair(1'b1, C_LW, {5'd1, 5'd0, 5'd3}, 1'b1, C_SW, {5'd2, 5'd4, 5'd0});
    step_cycle();
`ifdef DUAL_MEM_SPLIT_EN
    check_eq("mem_vld2", cmp_t'(vld2_e), cmp_t'(1'b0));
    step_cycle();
`else
    check_eq("mem_vld2", cmp_t'(vld2_e), cmp_t'(1'b1));
`endif

    // Randomized traffic; small register indices make hazards frequent.
    for (int i = 0; i < 400; i++) begin
      set_ctl(1'($urandom_range(0, 99) < 3),
              1'($urandom_range(0, 99) < 15),
              1'($urandom_range(0, 99) < 8));
      // Upstream keeps the pair stable while lane 2 is waiting.
      if (exp_q.size() == 0) begin
        set_pair(1'($urandom_range(0, 9) < 8), 8'($urandom),
                 {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))},
                 1'($urandom_range(0, 9) < 8), 8'($urandom),
                 {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))});
      end
      step_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
